mips_lite_cycle_ctrl: RTL and testbench
=======================================

MIPS_LITE_CYCLE_CTRL -- requirements
Module: mips_lite_cycle_ctrl

Interface
REQ-001 The block SHALL expose the following ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  begin execution from IDLE.
- opcode  input  3  instruction opcode from the instruction register; valid from DECODE onward.
- Zero  input  1  ALU zero flag; sampled in EXEC of BEQ.
- Mem_ready  input  1  memory handshake; access completes in the cycle it is high.
- IR_write  output  1  load the instruction register.
- PC_write  output  1  update the PC.
- PC_src  output  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump target.
- ALU_src_cntrl  output  1  ALU B operand: 0 = Rt_data, 1 = Imm.
- ALU_op  output  2  0 = add, 1 = sub, 2 = funct-defined.
- Reg_dst  output  1  destination register: 0 = Rt, 1 = Rd.
- Reg_write  output  1  register file write enable.
- Mem_read  output  1  data/instruction memory read.
- Mem_write  output  1  data memory write.
- Mem_to_reg  output  1  writeback source: 0 = ALU, 1 = memory.
- busy  output  1  high in every state except IDLE and HALT.
- halted  output  1  high only in HALT.
- instr_count  output  8  number of retired instructions; wraps 255 -> 0.

Function
REQ-002 Opcode encoding SHALL be: 0 = R-type, 1 = ADDI, 2 = LW, 3 = SW, 4 = BEQ, 5 = J, 7 = HALT; 6 is illegal.
REQ-003 The state register SHALL hold one of seven states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-004 All outputs except instr_count SHALL be Moore outputs: a combinational decode of the state and the opcode latched in DECODE. No output SHALL depend on start, Zero or Mem_ready, except PC_write, IR_write and Reg_write as stated below.
REQ-005 Transitions from IDLE and FETCH:
- IDLE -> FETCH when start = 1; otherwise hold IDLE.
- FETCH: Mem_read = 1; on Mem_ready = 1, IR_write = 1, PC_write = 1 and PC_src = 0, then go to DECODE; else stall in FETCH with IR_write = 0 and PC_write = 0.
REQ-006 DECODE SHALL latch opcode, then transition:
- opcode 7 -> HALT.
- opcode 6 -> FETCH, counted as retired.
- J -> EXEC.
- all others -> EXEC.
REQ-007 EXEC output settings and exits:
- R-type: ALU_src_cntrl = 0, ALU_op = 2, then -> WB.
- ADDI, LW, SW: ALU_src_cntrl = 1, ALU_op = 0; ADDI -> WB, LW and SW -> MEM.
- BEQ: ALU_src_cntrl = 0, ALU_op = 1, PC_src = 1, PC_write = Zero; then -> FETCH and retire.
- J: PC_src = 2, PC_write = 1; then -> FETCH and retire.
REQ-008 MEM: Mem_read = 1 for LW, Mem_write = 1 for SW, ALU_src_cntrl held at 1. On Mem_ready = 1, LW -> WB and SW -> FETCH (SW retires). Otherwise stall in MEM with outputs held.
REQ-009 WB: Reg_write = 1 for one cycle; Reg_dst = 1 for R-type only; Mem_to_reg = 1 for LW only; then -> FETCH and retire.
REQ-010 Retiring an instruction SHALL increment instr_count by 1 on the transition edge, modulo 256; HALT is not counted.
REQ-011 HALT SHALL be terminal: only rst_n leaves it, and start is ignored.
REQ-012 In every state, outputs not explicitly asserted for that state/opcode SHALL be 0.
REQ-013 Per-instruction latency, with Mem_ready tied high: R-type and ADDI 4 cycles; LW 5; SW 4; BEQ and J 3.

Reset
REQ-014 rst_n = 0 SHALL immediately, without waiting for a clock, force state = IDLE, all control outputs = 0, instr_count = 0 and the latched opcode = 0, including when asserted mid-instruction or mid-memory-stall.
REQ-015 After rst_n deasserts, the block SHALL remain in IDLE until start = 1 is sampled.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- ADDI, Mem_ready = 1: FETCH, DECODE, EXEC with ALU_src_cntrl = 1, WB with Reg_write = 1 and Reg_dst = 0; instr_count 0 -> 1 after 4 cycles.
- R-type followed by LW: ALU_src_cntrl is 0 in the R-type EXEC, then 1 in the LW EXEC and MEM; LW WB has Mem_to_reg = 1.
- SW with Mem_ready low for 3 MEM cycles: Mem_write stays high for 4 cycles and Reg_write is never asserted.
- BEQ with Zero = 1 and BEQ with Zero = 0: PC_write = 1 and PC_src = 1 in EXEC for the first, PC_write = 0 for the second.
- HALT after 255 retired instructions plus 1 more (count wraps to 0): halted = 1, busy = 0, and a start pulse has no effect.
- rst_n pulled low during a MEM stall: outputs go to 0 asynchronously; after release the block stays in IDLE until start.

Source files
------------

// File: rtl/mips_lite_cycle_ctrl.sv
// Multi-cycle control FSM for a small MIPS-like datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the
// datapath control strobes and counts retired instructions.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 leave IDLE and begin fetching
//   opcode[2:0]           instruction opcode, sampled and latched in DECODE
//   Zero                  ALU zero flag, used by BEQ in EXEC
//   Mem_ready             memory handshake, access completes when high
//   IR_write, PC_write, PC_src[1:0], ALU_src_cntrl, ALU_op[1:0], Reg_dst,
//   Reg_write, Mem_read, Mem_write, Mem_to_reg   datapath controls
//   busy, halted          status
//   instr_count[7:0]      retired instruction count, wraps modulo 256
module mips_lite_cycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       Zero,
  input  logic       Mem_ready,
  output logic       IR_write,
  output logic       PC_write,
  output logic [1:0] PC_src,
  output logic       ALU_src_cntrl,
  output logic [1:0] ALU_op,
  output logic       Reg_dst,
  output logic       Reg_write,
  output logic       Mem_read,
  output logic       Mem_write,
  output logic       Mem_to_reg,
  output logic       busy,
  output logic       halted,
  output logic [7:0] instr_count
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 8;

  localparam logic [OP_W-1:0] OP_RTYPE = 3'd0;
  localparam logic [OP_W-1:0] OP_ADDI  = 3'd1;
  localparam logic [OP_W-1:0] OP_LW    = 3'd2;
  localparam logic [OP_W-1:0] OP_SW    = 3'd3;
  localparam logic [OP_W-1:0] OP_BEQ   = 3'd4;
  localparam logic [OP_W-1:0] OP_J     = 3'd5;
  localparam logic [OP_W-1:0] OP_ILL   = 3'd6;
  localparam logic [OP_W-1:0] OP_HALT  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic            retire_c;

  // State, latched opcode and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (retire_c) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Next-state and Moore control decode from state and latched opcode
  always_comb begin
    state_d       = state_q;
    retire_c      = 1'b0;
    IR_write      = 1'b0;
    PC_write      = 1'b0;
    PC_src        = 2'd0;
    ALU_src_cntrl = 1'b0;
    ALU_op        = 2'd0;
    Reg_dst       = 1'b0;
    Reg_write     = 1'b0;
    Mem_read      = 1'b0;
    Mem_write     = 1'b0;
    Mem_to_reg    = 1'b0;
    busy          = 1'b0;
    halted        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        Mem_read = 1'b1;
        if (Mem_ready) begin
          IR_write = 1'b1;
          PC_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        busy = 1'b1;
        case (opcode)
          OP_HALT: state_d = S_HALT;
          OP_ILL: begin
            state_d  = S_FETCH;
            retire_c = 1'b1;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        busy = 1'b1;
        case (op_q)
          OP_RTYPE: begin
            ALU_op  = 2'd2;
            state_d = S_WB;
          end
          OP_ADDI: begin
            ALU_src_cntrl = 1'b1;
            state_d       = S_WB;
          end
          OP_LW, OP_SW: begin
            ALU_src_cntrl = 1'b1;
            state_d       = S_MEM;
          end
          OP_BEQ: begin
            ALU_op   = 2'd1;
            PC_src   = 2'd1;
            PC_write = Zero;
            state_d  = S_FETCH;
            retire_c = 1'b1;
          end
          OP_J: begin
            PC_src   = 2'd2;
            PC_write = 1'b1;
            state_d  = S_FETCH;
            retire_c = 1'b1;
          end
          // ILL/HALT never reach EXEC; recover to FETCH
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        busy          = 1'b1;
        ALU_src_cntrl = 1'b1;
        Mem_read      = (op_q == OP_LW);
        Mem_write     = (op_q == OP_SW);
        if (Mem_ready) begin
          // LW continues to writeback; a store completes here
          state_d  = (op_q == OP_LW) ? S_WB : S_FETCH;
          retire_c = (op_q != OP_LW);
        end
      end
      S_WB: begin
        busy       = 1'b1;
        Reg_write  = 1'b1;
        Reg_dst    = (op_q == OP_RTYPE);
        Mem_to_reg = (op_q == OP_LW);
        state_d    = S_FETCH;
        retire_c   = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_lite_cycle_ctrl.sv
// Self-checking bench for mips_lite_cycle_ctrl. Each instruction is expanded
// into its expected per-cycle control trace from opcode, stall counts and Zero.
// A negedge process compares the DUT outputs against that trace.
module tb_mips_lite_cycle_ctrl;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       busy;
    logic       halted;
    logic [7:0] count;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] opcode;
  logic       Zero;
  logic       Mem_ready;
  logic       IR_write, PC_write, ALU_src_cntrl, Reg_dst, Reg_write;
  logic       Mem_read, Mem_write, Mem_to_reg, busy, halted;
  logic [1:0] PC_src, ALU_op;
  logic [7:0] instr_count;

  mips_lite_cycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .Zero(Zero),
    .Mem_ready(Mem_ready), .IR_write(IR_write), .PC_write(PC_write),
    .PC_src(PC_src), .ALU_src_cntrl(ALU_src_cntrl), .ALU_op(ALU_op),
    .Reg_dst(Reg_dst), .Reg_write(Reg_write), .Mem_read(Mem_read),
    .Mem_write(Mem_write), .Mem_to_reg(Mem_to_reg), .busy(busy),
    .halted(halted), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t act_w;
  assign act_w = {IR_write, PC_write, PC_src, ALU_src_cntrl, ALU_op, Reg_dst,
                  Reg_write, Mem_read, Mem_write, Mem_to_reg, busy, halted,
                  instr_count};

  obs_t       exp_q;
  logic       chk_en = 1'b0;
  int         cmp_chk = 0, cmp_pass = 0;
  int         lit_chk = 0, lit_pass = 0;
  int         mw_cycles = 0, rw_cycles = 0;
  logic [7:0] mdl_count = 8'd0;
  int         retired = 0;

  // Per-cycle comparison against the expected trace
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_chk = cmp_chk + 1;
      if (act_w === exp_q) cmp_pass = cmp_pass + 1;
      else $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act_w, exp_q);
      if (act_w.mem_write) mw_cycles = mw_cycles + 1;
      if (act_w.reg_write) rw_cycles = rw_cycles + 1;
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    lit_chk = lit_chk + 1;
    if (act === req) lit_pass = lit_pass + 1;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] ro();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic obs_t active();
    obs_t e;
    e       = '0;
    e.busy  = 1'b1;
    e.count = mdl_count;
    return e;
  endfunction

  function automatic obs_t quiet(input logic h);
    obs_t e;
    e        = '0;
    e.halted = h;
    e.count  = mdl_count;
    return e;
  endfunction

  // One clock: apply inputs and expectation, advance past the next rising edge
  task automatic step(input obs_t e, input logic rdy, input logic z,
                      input logic [2:0] opc, input logic st);
    Mem_ready = rdy;
    Zero      = z;
    opcode    = opc;
    start     = st;
    exp_q     = e;
    chk_en    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    mdl_count = mdl_count + 8'd1;
    retired   = retired + 1;
  endtask

  // Expected trace of one instruction; rst_stall >= 0 stops in a MEM stall
  task automatic do_instr(input logic [2:0] op, input int fs, input int ms,
                          input logic z, input int rst_stall);
    obs_t e;
    for (int i = 0; i < fs; i++) begin
      e = active(); e.mem_read = 1'b1;
      step(e, 1'b0, rb(), ro(), rb());
    end
    e = active(); e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    step(e, 1'b1, rb(), ro(), rb());
    e = active();
    step(e, rb(), rb(), op, rb());
    if (op == 3'd7) return;
    if (op == 3'd6) begin retire(); return; end
    e = active();
    case (op)
      3'd0: e.alu_op = 2'd2;
      3'd4: begin e.alu_op = 2'd1; e.pc_src = 2'd1; e.pc_write = z; end
      3'd5: begin e.pc_src = 2'd2; e.pc_write = 1'b1; end
      default: e.alu_src = 1'b1;
    endcase
    step(e, rb(), z, ro(), rb());
    if (op == 3'd4 || op == 3'd5) begin retire(); return; end
    if (op == 3'd2 || op == 3'd3) begin
      e = active(); e.alu_src = 1'b1;
      e.mem_read = (op == 3'd2); e.mem_write = (op == 3'd3);
      for (int i = 0; i < ms; i++) begin
        step(e, 1'b0, rb(), ro(), rb());
        if (rst_stall >= 0 && i + 1 >= rst_stall) return;
      end
      step(e, 1'b1, rb(), ro(), rb());
      if (op == 3'd3) begin retire(); return; end
    end
    e = active(); e.reg_write = 1'b1;
    e.reg_dst = (op == 3'd0); e.mem_to_reg = (op == 3'd2);
    step(e, rb(), rb(), ro(), rb());
    retire();
  endtask

  // Async reset away from any edge; outputs must clear before the next edge
  task automatic reset_pulse(input string name);
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    lit(name, 32'(act_w), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mdl_count = 8'd0;
  endtask

  task automatic go();
    step(quiet(1'b0), rb(), rb(), ro(), 1'b1);
  endtask

  initial begin
    int mw0, rw0;
    rst_n = 1'b1; start = 1'b0; opcode = 3'd0; Zero = 1'b0; Mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 lit("reset_initial", 32'(act_w), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // IDLE holds without start
    for (int i = 0; i < 3; i++) step(quiet(1'b0), rb(), rb(), ro(), 1'b0);
    go();

    // ADDI retires after exactly four cycles
    do_instr(3'd1, 0, 0, 1'b0, -1);
    lit("addi_count", 32'(instr_count), 32'd1);

    // R-type then LW
    do_instr(3'd0, 0, 0, 1'b0, -1);
    do_instr(3'd2, 0, 0, 1'b0, -1);
    lit("rtype_lw_count", 32'(instr_count), 32'd3);

    // SW with three memory stalls
    mw0 = mw_cycles; rw0 = rw_cycles;
    do_instr(3'd3, 0, 3, 1'b0, -1);
    lit("sw_mem_write_cycles", 32'(mw_cycles - mw0), 32'd4);
    lit("sw_reg_write_cycles", 32'(rw_cycles - rw0), 32'd0);

    // BEQ taken and not taken, then J and an illegal opcode
    do_instr(3'd4, 0, 0, 1'b1, -1);
    do_instr(3'd4, 0, 0, 1'b0, -1);
    do_instr(3'd5, 1, 0, 1'b0, -1);
    do_instr(3'd6, 0, 0, 1'b0, -1);
    lit("directed_count", 32'(instr_count), 32'd8);

    // Random mix, then run on until the counter wraps back to zero
    for (int i = 0; i < 200; i++)
      do_instr(3'($urandom_range(0, 6)), $urandom_range(0, 2), $urandom_range(0, 2), rb(), -1);
    while (mdl_count != 8'd0)
      do_instr(3'($urandom_range(0, 6)), $urandom_range(0, 1), $urandom_range(0, 1), rb(), -1);
    lit("wrap_count", 32'(instr_count), 32'd0);
    lit("wrap_retired", 32'(retired), 32'd256);

    // HALT is terminal; start pulses are ignored
    do_instr(3'd7, 0, 0, 1'b0, -1);
    for (int i = 0; i < 4; i++) step(quiet(1'b1), rb(), rb(), ro(), 1'b1);
    lit("halt_halted", 32'(halted), 32'd1);
    lit("halt_busy", 32'(busy), 32'd0);
    lit("halt_count", 32'(instr_count), 32'd0);

    // Reset leaves HALT; then reset again in the middle of an LW memory stall
    reset_pulse("reset_from_halt");
    for (int i = 0; i < 2; i++) step(quiet(1'b0), rb(), rb(), ro(), 1'b0);
    go();
    do_instr(3'd1, 0, 0, 1'b0, -1);
    do_instr(3'd2, 0, 3, 1'b0, 2);
    lit("pre_reset_mem_read", 32'(Mem_read), 32'd1);
    reset_pulse("reset_mem_stall");
    for (int i = 0; i < 4; i++) step(quiet(1'b0), 1'b1, rb(), ro(), 1'b0);
    lit("post_reset_idle_busy", 32'(busy), 32'd0);
    go();
    do_instr(3'd2, 1, 1, 1'b0, -1);
    do_instr(3'd5, 0, 0, 1'b0, -1);
    lit("post_reset_count", 32'(instr_count), 32'd2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", cmp_pass + lit_pass, cmp_chk + lit_chk);
    $finish;
  end

endmodule
